slicel_cfg_loader: RTL
======================

Name: slicel_cfg_loader

Overview:
- Configuration loader that sits directly upstream of the standard logic slice.
- Accepts a word-wide configuration stream through a valid/ready handshake and assembles a shadow image of every LUT's config bits plus the carry-chain enable bit.
- Once the image is complete, issues a single-cycle config-enable pulse so the slice captures the whole image atomically on cclk.

Parameters:
- S_XX_BASE, 4, LUT input base; sets per-LUT config size.
- CFG_SIZE, 2**S_XX_BASE+1, config bits per LUT half; each LUT takes 2*CFG_SIZE bits.
- NUM_LUTS, 4, number of LUTs in the slice.
- IN_W, 8, width of one stream word.
- Derived: TOT_BITS = NUM_LUTS*2*CFG_SIZE+1 (137 at defaults).
- Derived: WORDS = ceil(TOT_BITS/IN_W) (18 at defaults).

Ports:
- cclk  input  1  configuration clock; the single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new load; sampled only in IDLE or ERROR.
- cfg_data  input  IN_W  stream word.
- cfg_valid  input  1  cfg_data is valid.
- cfg_last  input  1  marks the final word of the frame; qualified by cfg_valid.
- cfg_ready  output  1  loader accepts a word this cycle.
- luts_config_out  output  NUM_LUTS*2*CFG_SIZE  shadow image; LUT i occupies bits [i*2*CFG_SIZE +: 2*CFG_SIZE].
- use_cc_out  output  1  carry-chain enable bit from the image.
- cen  output  1  one-cycle commit strobe to the slice.
- busy  output  1  high in LOAD and COMMIT.
- done  output  1  one-cycle pulse after a successful commit.
- err  output  1  sticky frame error.

Behaviour:
- Reset: asynchronous; all outputs and shadow registers go to 0; state = IDLE; word counter = 0.
- States: IDLE, LOAD, COMMIT, ERROR.
- IDLE:
  - cfg_ready=0.
  - start=1 → LOAD next cycle, counter cleared.
- LOAD:
  - cfg_ready=1 and busy=1.
  - A word is accepted on cfg_valid & cfg_ready.
  - Stream bit k = word (k / IN_W), bit (k % IN_W); word 0 arrives first.
  - Bits 0..TOT_BITS-2 map to luts_config_out[k].
  - Bit TOT_BITS-1 maps to use_cc_out.
  - Padding bits at or above TOT_BITS in the last word are discarded.
  - Words are written directly into the shadow registers at their computed offset, so outputs change during LOAD. The slice ignores them because cen=0.
- Frame check:
  - Accepted word with counter==WORDS-1 and cfg_last=1 → COMMIT.
  - cfg_last=1 at any other counter value → ERROR.
  - Counter==WORDS-1 with cfg_last=0 → ERROR.
- COMMIT:
  - cfg_ready=0, cen=1 for exactly this one cycle.
  - Shadow outputs are stable.
  - Next cycle: IDLE with done=1 for one cycle.
- ERROR:
  - err=1 (sticky), cfg_ready=0, cen never asserted.
  - Shadow contents are undefined to the consumer.
  - start=1 → clears err and enters LOAD.
- start while in LOAD or COMMIT is ignored.
- cfg_valid in IDLE or ERROR is ignored; no word is consumed.
- Latency: cen asserts the cycle after the last word handshake; done asserts the cycle after cen.
- Minimum frame time is WORDS+2 cycles from the first accepted word to done.
- Outputs hold their values after commit until the next LOAD writes them.
- Reset mid-LOAD or mid-COMMIT aborts immediately; cen is forced to 0.

Optional Feature:
- Macro: SLICEL_CFG_CHECKSUM_EN.
- When defined:
  - Frame length is WORDS+1; cfg_last is expected on the extra word.
  - The extra word must equal the bitwise XOR of all WORDS data words.
  - Match → COMMIT; mismatch → ERROR with no cen.
  - The checksum word is never written to the shadow registers.
- When undefined: frame is exactly WORDS words and no checksum logic is present.

Test Plan:
- Reset, then start, then 18 words with value 0xA5 and cfg_last on word 17 → cen high exactly 1 cycle after the last handshake; done 1 cycle later; luts_config_out = repeating 0xA5 pattern; use_cc_out = bit 0 of word 17 = 1.
- Same frame with cfg_valid toggled 0/1 on alternating cycles → identical image; cen asserted once; no word dropped or duplicated.
- cfg_last asserted on word 5 → err=1, cen never asserted. A following start plus a valid frame clears err and commits normally.
- 18 words with cfg_last=0 on word 17 → ERROR, cfg_ready=0, cen=0.
- rst asserted mid-LOAD after 9 words → all outputs 0 immediately; after a new start, a full frame commits correctly.
- With SLICEL_CFG_CHECKSUM_EN defined, 18 words of 0x01..0x12 followed by checksum 0x13 → commit. A checksum of 0x00 instead → err=1, no cen.

Source files
------------

// File: rtl/slicel_cfg_loader_if.sv
// rtl/slicel_cfg_loader_if.sv - configuration word stream between a source and the slice loader
interface slicel_cfg_loader_if #(
    parameter int IN_W = 8
);
    logic [IN_W-1:0] cfg_data;
    logic            cfg_valid;
    logic            cfg_last;
    logic            cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/slicel_cfg_loader.sv
// rtl/slicel_cfg_loader.sv - assembles a slice config image from a word stream and commits it with cen
// Optional trailing XOR checksum word enabled by SLICEL_CFG_CHECKSUM_EN.
module slicel_cfg_loader #(
    parameter int S_XX_BASE = 4,
    parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
    parameter int NUM_LUTS  = 4,
    parameter int IN_W      = 8
) (
    input  logic                           cclk,
    input  logic                           rst,
    input  logic                           start,
    slicel_cfg_loader_if.slave             cfg,
    output logic [NUM_LUTS*2*CFG_SIZE-1:0] luts_config_out,
    output logic                           use_cc_out,
    output logic                           cen,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int LUT_BITS = NUM_LUTS * 2 * CFG_SIZE;
    localparam int TOT_BITS = LUT_BITS + 1;
    localparam int WORDS    = (TOT_BITS + IN_W - 1) / IN_W;
`ifdef SLICEL_CFG_CHECKSUM_EN
    localparam int FRAME_LEN = WORDS + 1;
`else
    localparam int FRAME_LEN = WORDS;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LUT_BITS-1:0] luts_q, luts_d;
    logic                use_cc_q, use_cc_d;
    logic                done_q, done_d;
    logic                final_word;
    logic                sum_ok;
`ifdef SLICEL_CFG_CHECKSUM_EN
    logic [IN_W-1:0]     xor_q, xor_d;
`endif

    assign final_word = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        int k;
        state_d  = state_q;
        cnt_d    = cnt_q;
        luts_d   = luts_q;
        use_cc_d = use_cc_q;
        done_d   = 1'b0;
        sum_ok   = 1'b1;
        k        = 0;
`ifdef SLICEL_CFG_CHECKSUM_EN
        xor_d    = xor_q;
`endif
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
`ifdef SLICEL_CFG_CHECKSUM_EN
                    xor_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (cfg.cfg_valid) begin
`ifdef SLICEL_CFG_CHECKSUM_EN
                    // The checksum word is compared, never stored.
                    sum_ok = (cfg.cfg_data == xor_q);
                    if (cnt_q < CNT_W'(WORDS)) begin
                        xor_d = xor_q ^ cfg.cfg_data;
`endif
                        for (int j = 0; j < IN_W; j++) begin
                            k = int'(cnt_q) * IN_W + j;
                            if (k < LUT_BITS) begin
                                luts_d[k] = cfg.cfg_data[j];
                            end else if (k == LUT_BITS) begin
                                use_cc_d = cfg.cfg_data[j];
                            end
                        end
`ifdef SLICEL_CFG_CHECKSUM_EN
                    end
`endif
                    if (cfg.cfg_last) begin
                        state_d = (final_word && sum_ok) ? ST_COMMIT : ST_ERROR;
                    end else if (final_word) begin
                        state_d = ST_ERROR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            luts_q   <= '0;
            use_cc_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SLICEL_CFG_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            luts_q   <= luts_d;
            use_cc_q <= use_cc_d;
            done_q   <= done_d;
`ifdef SLICEL_CFG_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    assign cfg.cfg_ready    = (state_q == ST_LOAD);
    assign busy             = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
    assign cen              = (state_q == ST_COMMIT);
    assign err              = (state_q == ST_ERROR);
    assign done             = done_q;
    assign luts_config_out  = luts_q;
    assign use_cc_out       = use_cc_q;
endmodule
